bus_serial_tx: RTL and testbench

- Upstream serializer for the DUT's serial port: takes parallel bus commands (cmd, addr, data) over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each command out as a framed bit stream on serial_out with a generated serial_clk, wired directly to the DUT's serial_clk/serial_in inputs.
- Single clock domain.

---
 rtl/bus_serial_tx.sv | 169 ++++++++++++++++
 tb/tb_bus_serial_tx.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_serial_tx.sv
// Command FIFO plus frame serializer driving a bit clock and data line toward the DUT serial port.
// Build option BUS_SERIAL_TX_PARITY_EN inserts an even-parity bit before the stop bit.
module bus_serial_tx #(
    parameter int FIFO_DEPTH = 4,
    parameter int CLK_DIV    = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_cmd,
    input  logic [7:0]                    in_addr,
    input  logic [7:0]                    in_data,
    output logic                          serial_clk,
    output logic                          serial_out,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int DIV_W = $clog2(CLK_DIV);
`ifdef BUS_SERIAL_TX_PARITY_EN
    localparam int FRAME_LEN = 20;
`else
    localparam int FRAME_LEN = 19;
`endif
    localparam int SHIFT_W = FRAME_LEN - 1;

    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [DIV_W-1:0] DIV_LOAD  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF  = DIV_W'(CLK_DIV / 2);
    localparam logic [4:0]       BITS_LOAD = 5'(FRAME_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             state_q, state_d;
    logic [16:0]        mem_q [FIFO_DEPTH];
    logic [16:0]        mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [4:0]         bits_q, bits_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               sout_q, sout_d;
    logic               sclk_q, sclk_d;
    logic               busy_q, busy_d;

    logic               push;
    logic               pop;
    logic               count_nz;
    logic [16:0]        head;
    logic [SHIFT_W-1:0] frame_body;

    assign in_ready   = (count_q < DEPTH_C);
    assign push       = in_valid && in_ready;
    assign count_nz   = (count_q != '0);
    assign head       = mem_q[rd_ptr_q];
    assign serial_out = sout_q;
    assign serial_clk = sclk_q;
    assign busy       = busy_q;
    assign fifo_count = count_q;

    // Everything after the start bit, in transmit order; the stop bit is the LSB.
`ifdef BUS_SERIAL_TX_PARITY_EN
    assign frame_body = {head, ^head, 1'b1};
`else
    assign frame_body = {head, 1'b1};
`endif

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bits_d  = bits_q;
        shift_d = shift_q;
        sout_d  = sout_q;
        busy_d  = busy_q;
        pop     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (count_nz) begin
                    pop     = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (div_q != '0) begin
                    div_d = div_q - DIV_W'(1);
                end else if (bits_q != '0) begin
                    bits_d  = bits_q - 5'd1;
                    sout_d  = shift_q[SHIFT_W-1];
                    shift_d = {shift_q[SHIFT_W-2:0], 1'b1};
                    div_d   = DIV_LOAD;
                end else if (count_nz) begin
                    pop = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    sout_d  = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                sout_d  = 1'b1;
                busy_d  = 1'b0;
            end
        endcase

        // A pop always begins a new frame with its start bit.
        if (pop) begin
            shift_d = frame_body;
            sout_d  = 1'b0;
            bits_d  = BITS_LOAD;
            div_d   = DIV_LOAD;
            busy_d  = 1'b1;
        end

        sclk_d = (state_d == S_SHIFT) && (div_d < DIV_HALF);
    end

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = {in_cmd, in_addr, in_data};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            div_q    <= '0;
            bits_q   <= '0;
            shift_q  <= '1;
            sout_q   <= 1'b1;
            sclk_q   <= 1'b0;
            busy_q   <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            div_q    <= div_d;
            bits_q   <= bits_d;
            shift_q  <= shift_d;
            sout_q   <= sout_d;
            sclk_q   <= sclk_d;
            busy_q   <= busy_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_bus_serial_tx.sv
// Bench for bus_serial_tx: every accepted command is expanded into its expected frame bits,
// which are matched against serial_out sampled at each serial_clk rise.
module tb_bus_serial_tx;
    localparam int FIFO_DEPTH = 4;
    localparam int CLK_DIV    = 4;
`ifdef BUS_SERIAL_TX_PARITY_EN
    localparam int FRAME_LEN = 20;
`else
    localparam int FRAME_LEN = 19;
`endif
    localparam int FRAME_CYC = FRAME_LEN * CLK_DIV;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_cmd = 1'b0;
    logic [7:0] in_addr = '0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       serial_clk;
    logic       serial_out;
    logic       busy;
    logic [2:0] fifo_count;

    int   checks = 0;
    int   failures = 0;
    bit   exp_q[$];
    int   rise_cnt = 0;
    int   busy_run = 0;
    int   last_busy_len = 0;
    logic sclk_prev = 1'b0;

    bus_serial_tx #(.FIFO_DEPTH(FIFO_DEPTH), .CLK_DIV(CLK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_cmd     (in_cmd),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .serial_clk (serial_clk),
        .serial_out (serial_out),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Frame model: start 0, cmd, addr MSB first, data MSB first, optional even parity, stop 1.
    function automatic void add_frame(input logic c, input logic [7:0] a, input logic [7:0] d);
        logic [16:0] payload;
        int ones;
        payload = {c, a, d};
        ones = 0;
        exp_q.push_back(1'b0);
        for (int i = 16; i >= 0; i--) begin
            exp_q.push_back(payload[i]);
            ones += int'(payload[i]);
        end
`ifdef BUS_SERIAL_TX_PARITY_EN
        exp_q.push_back(ones % 2 == 1);
`endif
        exp_q.push_back(1'b1);
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            sclk_prev = 1'b0;
            busy_run  = 0;
        end else begin
            if (serial_clk && !sclk_prev) begin
                rise_cnt++;
                if (exp_q.size() == 0) chk("extra_bit", 1, 0);
                else chk("frame_bit", serial_out, exp_q.pop_front());
            end
            sclk_prev = serial_clk;
            if (busy) busy_run++;
            else if (busy_run != 0) begin
                last_busy_len = busy_run;
                busy_run = 0;
            end
            if (in_valid && in_ready) add_frame(in_cmd, in_addr, in_data);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic c, input logic [7:0] a, input logic [7:0] d);
        int guard;
        guard = 0;
        in_cmd = c; in_addr = a; in_data = d; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("send_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cyc);
        int n;
        n = 0;
        @(negedge clk);
        while ((busy || fifo_count != 0) && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(busy || fifo_count != 0), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0, acc, first_drop, guard;
        logic ok;

        #2 rst_n = 1'b0;
        #20;
        chk("rst_sout", serial_out, 1);
        chk("rst_sclk", serial_clk, 0);
        chk("rst_busy", busy, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write 0x3C/0xA5 with latency and timing checks
        r0 = rise_cnt;
        in_cmd = 1'b1; in_addr = 8'h3C; in_data = 8'hA5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("lat_pre_busy", busy, 0);
        chk("lat_pre_sout", serial_out, 1);
        chk("lat_count", fifo_count, 1);
        @(posedge clk); #1;
        chk("lat_start_bit", serial_out, 0);
        chk("lat_busy", busy, 1);
        chk("lat_sclk_low", serial_clk, 0);
        tick(CLK_DIV / 2 - 1);
        chk("lat_sclk_still_low", serial_clk, 0);
        tick(1);
        chk("lat_first_rise", serial_clk, 1);
        wait_idle(4 * FRAME_CYC);
        chk("t1_rises", rise_cnt - r0, FRAME_LEN);
        chk("t1_busy_len", last_busy_len, FRAME_CYC);
        chk("t1_idle_line", serial_out, 1);
        chk("t1_idle_sclk", serial_clk, 0);
        chk("t1_queue_empty", exp_q.size(), 0);

        // Read with all-ones address and all-zeros data
        r0 = rise_cnt;
        send(1'b0, 8'hFF, 8'h00);
        wait_idle(4 * FRAME_CYC);
        chk("rd_rises", rise_cnt - r0, FRAME_LEN);
        chk("rd_busy_len", last_busy_len, FRAME_CYC);

        // Hold in_valid through six commands: FIFO fills, frames run back to back
        acc = 0; first_drop = -1; guard = 0;
        while (acc < 6 && guard < 2000) begin
            in_cmd = acc[0];
            in_addr = 8'(acc * 17 + 3);
            in_data = 8'(8'hF0 ^ acc);
            in_valid = 1'b1;
            @(negedge clk);
            ok = in_ready;
            if (!ok && first_drop < 0) begin
                first_drop = acc;
                chk("fill_count_full", fifo_count, FIFO_DEPTH);
            end
            @(posedge clk); #1;
            if (ok) acc++;
            guard++;
        end
        in_valid = 1'b0;
        chk("fill_accepted_before_drop", first_drop, 5);
        chk("fill_all_accepted", acc, 6);
        wait_idle(10 * FRAME_CYC);
        chk("fill_busy_len", last_busy_len, 6 * FRAME_CYC);
        chk("fill_queue_empty", exp_q.size(), 0);

        // Reset in the middle of a frame with another command queued
        send(1'b1, 8'h11, 8'h22);
        send(1'b0, 8'h33, 8'h44);
        tick(30);
        chk("mid_busy_pre", busy, 1);
        chk("mid_sclk_pre", serial_clk, 1);
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_sout", serial_out, 1);
        chk("mid_rst_sclk", serial_clk, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_busy", busy, 0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        r0 = rise_cnt;
        send(1'b1, 8'h5A, 8'hC3);
        wait_idle(4 * FRAME_CYC);
        chk("post_rst_rises", rise_cnt - r0, FRAME_LEN);
        chk("post_rst_busy_len", last_busy_len, FRAME_CYC);
        chk("post_rst_queue_empty", exp_q.size(), 0);

        // Parity-sensitive frame: W, addr 0x01, data 0x01
        r0 = rise_cnt;
        send(1'b1, 8'h01, 8'h01);
        wait_idle(4 * FRAME_CYC);
        chk("par_rises", rise_cnt - r0, FRAME_LEN);

        // Push lands on the same edge that pops the last queued entry
        in_cmd = 1'b1; in_addr = 8'hA1; in_data = 8'h1A; in_valid = 1'b1;
        @(posedge clk); #1;
        in_cmd = 1'b0; in_addr = 8'hB2; in_data = 8'h2B;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pp_count_start", fifo_count, 1);
        tick(FRAME_CYC - 1);
        chk("pp_busy_end", busy, 1);
        chk("pp_stop_bit", serial_out, 1);
        chk("pp_count_mid", fifo_count, 1);
        in_cmd = 1'b1; in_addr = 8'hC3; in_data = 8'h3C; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pp_count_same_edge", fifo_count, 1);
        chk("pp_next_start", serial_out, 0);
        wait_idle(5 * FRAME_CYC);
        chk("pp_busy_len", last_busy_len, 3 * FRAME_CYC);
        chk("pp_queue_empty", exp_q.size(), 0);

        // Random commands with random idle gaps
        for (int k = 0; k < 25; k++) begin
            send(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom));
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 120));
        end
        wait_idle(30 * FRAME_CYC);
        chk("rand_queue_empty", exp_q.size(), 0);
        chk("rand_count_zero", fifo_count, 0);
        chk("rand_idle_line", serial_out, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
